// File: rtl/cpumc_arb.sv
// Registered N-master arbiter for the CPU memory-controller bus, with a one-cycle handover gap and an optional hold timeout.
// Define CPUMC_ARB_RR_EN for round-robin selection among the non-default masters. Without it, the lowest index wins.
module cpumc_arb #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int DEF_MASTER  = 2,
  parameter int MAX_HOLD    = 0,
  parameter int OW          = 3
) (
  input  logic                      clk_in,
  input  logic                      nrst_in,
  input  logic [NUM_MASTERS-1:0]    req_in,
  input  logic [NUM_MASTERS*AW-1:0] a_in,
  input  logic [NUM_MASTERS-1:0]    r_nw_in,
  input  logic [NUM_MASTERS*DW-1:0] d_in,
  output logic [NUM_MASTERS-1:0]    gnt_out,
  output logic [AW-1:0]             a_out,
  output logic                      r_nw_out,
  output logic [DW-1:0]             d_out,
  output logic [OW-1:0]             owner_out,
  output logic                      gap_out,
  output logic                      tmo_out
);

  // state  | meaning
  // ST_OWN | owner_q holds the bus and its grant is asserted
  // ST_GAP | one-cycle handover: no grant, bus forced to an idle read
  typedef enum logic {ST_OWN, ST_GAP} state_t;

  localparam logic [NUM_MASTERS-1:0] DEF_MASK  = NUM_MASTERS'(1) << DEF_MASTER;
  localparam int                     HW        = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]          HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  if (DEF_MASTER < 0 || DEF_MASTER >= NUM_MASTERS) begin : g_bad_def
    $fatal(1, "cpumc_arb: DEF_MASTER out of range");
  end
  if ((1 << OW) < NUM_MASTERS) begin : g_bad_ow
    $fatal(1, "cpumc_arb: OW too narrow for NUM_MASTERS");
  end

  state_t                 state_q, state_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   tmo_q, tmo_d;
  logic [NUM_MASTERS-1:0] nd_req;
  logic [OW-1:0]          winner;
  logic                   owner_req, others_pend;

  assign nd_req      = req_in & ~DEF_MASK;
  assign owner_req   = |(req_in & gnt_q);
  assign others_pend = |(nd_req & ~gnt_q);

`ifdef CPUMC_ARB_RR_EN
  logic [OW-1:0] last_q;
  logic          found;
  int            idx;

  // Walk forward from the master after the last non-default owner; DEF_MASTER is already masked out.
  always_comb begin
    winner = OW'(DEF_MASTER);
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(last_q) + k) % NUM_MASTERS;
      if (!found && nd_req[idx]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!nrst_in)
      last_q <= OW'(NUM_MASTERS - 1);
    else if (state_q == ST_GAP && winner != OW'(DEF_MASTER))
      last_q <= winner;
  end
`else
  always_comb begin
    winner = OW'(DEF_MASTER);
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (nd_req[i]) winner = OW'(i);
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_OWN: begin
        if (owner_q == OW'(DEF_MASTER)) begin
          if (|nd_req) begin
            state_d = ST_GAP;
            gnt_d   = '0;
          end
        end else if (!owner_req) begin
          state_d = ST_GAP;
          gnt_d   = '0;
        end else if (MAX_HOLD > 0 && others_pend) begin
          // A release on the same edge is handled above, so a timeout never coincides with one.
          if (hold_q == HOLD_LAST) begin
            state_d = ST_GAP;
            gnt_d   = '0;
            tmo_d   = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_OWN;
        owner_d = winner;
        gnt_d   = NUM_MASTERS'(1) << winner;
        hold_d  = '0;
      end
      default: begin
        state_d = ST_OWN;
        owner_d = OW'(DEF_MASTER);
        gnt_d   = DEF_MASK;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!nrst_in) begin
      state_q <= ST_OWN;
      owner_q <= OW'(DEF_MASTER);
      gnt_q   <= DEF_MASK;
      hold_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
    end
  end

  // The bus is an idle read during the gap, so a stale owner can never issue a write.
  always_comb begin
    a_out    = '0;
    r_nw_out = 1'b1;
    d_out    = '0;
    if (state_q == ST_OWN) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (owner_q == OW'(i)) begin
          a_out    = a_in[i*AW +: AW];
          r_nw_out = r_nw_in[i];
          d_out    = d_in[i*DW +: DW];
        end
      end
    end
  end

  assign gnt_out   = gnt_q;
  assign owner_out = owner_q;
  assign gap_out   = (state_q == ST_GAP);
  assign tmo_out   = tmo_q;

endmodule

// File: tb/tb_cpumc_arb.sv
// Self-checking bench for cpumc_arb: a directed vector table, hand-written timeout sequences, and randomized traffic.
// Two instances are driven in parallel: one with no hold limit and one with MAX_HOLD = 4.
module tb_cpumc_arb;
  localparam int N   = 3;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int DEF = 2;

  logic          clk_in = 1'b0;
  logic          nrst_in;
  logic [N-1:0]  req_in;
  logic [N*AW-1:0] a_in;
  logic [N-1:0]  r_nw_in;
  logic [N*DW-1:0] d_in;

  logic [N-1:0]  gnt_o   [2];
  logic [AW-1:0] a_o     [2];
  logic          r_nw_o  [2];
  logic [DW-1:0] d_o     [2];
  logic [2:0]    owner_o [2];
  logic          gap_o   [2];
  logic          tmo_o   [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  cpumc_arb #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .DEF_MASTER(DEF), .MAX_HOLD(0), .OW(3)) dut_f (
    .clk_in(clk_in), .nrst_in(nrst_in), .req_in(req_in), .a_in(a_in), .r_nw_in(r_nw_in), .d_in(d_in),
    .gnt_out(gnt_o[0]), .a_out(a_o[0]), .r_nw_out(r_nw_o[0]), .d_out(d_o[0]),
    .owner_out(owner_o[0]), .gap_out(gap_o[0]), .tmo_out(tmo_o[0]));

  cpumc_arb #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .DEF_MASTER(DEF), .MAX_HOLD(4), .OW(3)) dut_t (
    .clk_in(clk_in), .nrst_in(nrst_in), .req_in(req_in), .a_in(a_in), .r_nw_in(r_nw_in), .d_in(d_in),
    .gnt_out(gnt_o[1]), .a_out(a_o[1]), .r_nw_out(r_nw_o[1]), .d_out(d_o[1]),
    .owner_out(owner_o[1]), .gap_out(gap_o[1]), .tmo_out(tmo_o[1]));

  // Reference model: who owns the bus, whether this is a gap cycle, and how long the owner has made others wait.
  typedef struct {
    bit gap;
    int owner;
    int waited;
    bit tmo;
    int last;
  } model_t;

  model_t mdl [2];
  int     limit [2] = '{0, 4};

  function automatic model_t reset_model();
    model_t r;
    r.gap = 0; r.owner = DEF; r.waited = 0; r.tmo = 0; r.last = N - 1;
    return r;
  endfunction

  function automatic model_t step(model_t s, logic [N-1:0] req, bit rst, int lim);
    model_t n;
    int     cands[$];
    bit     others;
    if (rst) return reset_model();
    n = s;
    n.tmo = 0;
    if (s.gap) begin
      for (int i = 0; i < N; i++)
        if (i != DEF && req[i]) cands.push_back(i);
`ifdef CPUMC_ARB_RR_EN
      // Rotate the candidate list so that the search starts just after the last owner.
      while (cands.size() > 0 && cands[0] <= s.last && cands[$] > s.last)
        cands.push_back(cands.pop_front());
`endif
      n.gap    = 0;
      n.owner  = (cands.size() > 0) ? cands[0] : DEF;
      n.waited = 0;
      if (n.owner != DEF) n.last = n.owner;
    end else begin
      others = 0;
      for (int i = 0; i < N; i++)
        if (i != DEF && i != s.owner && req[i]) others = 1;
      if (s.owner == DEF) begin
        if (others) n.gap = 1;
      end else if (!req[s.owner]) begin
        n.gap = 1;
      end else if (lim > 0 && others) begin
        n.waited = s.waited + 1;
        if (n.waited == lim) begin
          n.gap = 1;
          n.tmo = 1;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(int k);
    logic [N-1:0]  e_gnt;
    logic [AW-1:0] e_a;
    logic          e_rnw;
    logic [DW-1:0] e_d;
    e_gnt = mdl[k].gap ? '0 : (N'(1) << mdl[k].owner);
    e_a   = mdl[k].gap ? '0 : a_in[mdl[k].owner*AW +: AW];
    e_rnw = mdl[k].gap ? 1'b1 : r_nw_in[mdl[k].owner];
    e_d   = mdl[k].gap ? '0 : d_in[mdl[k].owner*DW +: DW];
    chk($sformatf("m%0d_gnt", k), 32'(gnt_o[k]), 32'(e_gnt));
    chk($sformatf("m%0d_gap", k), 32'(gap_o[k]), 32'(mdl[k].gap));
    chk($sformatf("m%0d_tmo", k), 32'(tmo_o[k]), 32'(mdl[k].tmo));
    chk($sformatf("m%0d_a", k), 32'(a_o[k]), 32'(e_a));
    chk($sformatf("m%0d_rnw", k), 32'(r_nw_o[k]), 32'(e_rnw));
    chk($sformatf("m%0d_d", k), 32'(d_o[k]), 32'(e_d));
    if (!mdl[k].gap) chk($sformatf("m%0d_owner", k), 32'(owner_o[k]), 32'(mdl[k].owner));
  endtask

  // One clock: both models advance on the edge, then every output of both instances is compared.
  task automatic tick();
    @(posedge clk_in);
    for (int k = 0; k < 2; k++) mdl[k] = step(mdl[k], req_in, !nrst_in, limit[k]);
    #1;
    check_model(0);
    check_model(1);
  endtask

  typedef struct {
    logic         nrst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gap;
    logic [15:0]  a;
    logic         rnw;
  } vec_t;

  vec_t vecs [22];

  initial begin
    nrst_in = 1'b0;
    req_in  = '0;
    a_in    = {16'h8000, 16'h2004, 16'h1000};
    r_nw_in = 3'b101;
    d_in    = {8'hC2, 8'hB1, 8'hA0};
    mdl[0]  = reset_model();
    mdl[1]  = reset_model();

    //            nrst  req     gnt     gap  a         rnw
    vecs[0]  = '{1'b0, 3'b000, 3'b100, 1'b0, 16'h8000, 1'b1};
    vecs[1]  = '{1'b1, 3'b000, 3'b100, 1'b0, 16'h8000, 1'b1};
    vecs[2]  = '{1'b1, 3'b010, 3'b000, 1'b1, 16'h0000, 1'b1};
    vecs[3]  = '{1'b1, 3'b010, 3'b010, 1'b0, 16'h2004, 1'b0};
    vecs[4]  = '{1'b1, 3'b011, 3'b010, 1'b0, 16'h2004, 1'b0};
    vecs[5]  = '{1'b1, 3'b011, 3'b010, 1'b0, 16'h2004, 1'b0};
    vecs[6]  = '{1'b1, 3'b001, 3'b000, 1'b1, 16'h0000, 1'b1};
    vecs[7]  = '{1'b1, 3'b001, 3'b001, 1'b0, 16'h1000, 1'b1};
    vecs[8]  = '{1'b1, 3'b000, 3'b000, 1'b1, 16'h0000, 1'b1};
    vecs[9]  = '{1'b1, 3'b000, 3'b100, 1'b0, 16'h8000, 1'b1};
    vecs[10] = '{1'b1, 3'b011, 3'b000, 1'b1, 16'h0000, 1'b1};
    vecs[11] = '{1'b1, 3'b011, 3'b001, 1'b0, 16'h1000, 1'b1};
    vecs[12] = '{1'b1, 3'b010, 3'b000, 1'b1, 16'h0000, 1'b1};
    vecs[13] = '{1'b1, 3'b010, 3'b010, 1'b0, 16'h2004, 1'b0};
    vecs[14] = '{1'b0, 3'b010, 3'b100, 1'b0, 16'h8000, 1'b1};
    vecs[15] = '{1'b1, 3'b000, 3'b100, 1'b0, 16'h8000, 1'b1};
    vecs[16] = '{1'b1, 3'b010, 3'b000, 1'b1, 16'h0000, 1'b1};
    vecs[17] = '{1'b1, 3'b010, 3'b010, 1'b0, 16'h2004, 1'b0};
    vecs[18] = '{1'b1, 3'b000, 3'b000, 1'b1, 16'h0000, 1'b1};
    vecs[19] = '{1'b1, 3'b010, 3'b010, 1'b0, 16'h2004, 1'b0};
    vecs[20] = '{1'b1, 3'b001, 3'b000, 1'b1, 16'h0000, 1'b1};
    vecs[21] = '{1'b1, 3'b000, 3'b100, 1'b0, 16'h8000, 1'b1};

    tick();
    for (int v = 0; v < 22; v++) begin
      nrst_in = vecs[v].nrst;
      req_in  = vecs[v].req;
      tick();
      chk($sformatf("vec%0d_gnt", v), 32'(gnt_o[0]), 32'(vecs[v].gnt));
      chk($sformatf("vec%0d_gap", v), 32'(gap_o[0]), 32'(vecs[v].gap));
      chk($sformatf("vec%0d_a", v), 32'(a_o[0]), 32'(vecs[v].a));
      chk($sformatf("vec%0d_rnw", v), 32'(r_nw_o[0]), 32'(vecs[v].rnw));
      chk($sformatf("vec%0d_tmo", v), 32'(tmo_o[0]), 32'(1'b0));
    end

    // Timeout: master 1 owns while master 0 waits for four cycles.
    req_in = 3'b010; tick(); tick();
    req_in = 3'b011;
    for (int c = 0; c < 3; c++) tick();
    chk("hold3_gnt_t", 32'(gnt_o[1]), 32'(3'b010));
    chk("hold3_tmo_t", 32'(tmo_o[1]), 32'(1'b0));
    tick();
    chk("tmo_pulse_t", 32'(tmo_o[1]), 32'(1'b1));
    chk("tmo_gap_t", 32'(gap_o[1]), 32'(1'b1));
    chk("tmo_gnt_t", 32'(gnt_o[1]), 32'(3'b000));
    chk("nolimit_gnt_f", 32'(gnt_o[0]), 32'(3'b010));
    tick();
    chk("after_tmo_gnt_t", 32'(gnt_o[1]), 32'(3'b001));
    chk("after_tmo_pulse_t", 32'(tmo_o[1]), 32'(1'b0));

    // Release on the edge the timeout would fire: treated as a release, no pulse.
    for (int c = 0; c < 3; c++) tick();
    req_in = 3'b010; tick();
    chk("rel_vs_tmo_gap_t", 32'(gap_o[1]), 32'(1'b1));
    chk("rel_vs_tmo_pulse_t", 32'(tmo_o[1]), 32'(1'b0));
    tick();
    chk("rel_vs_tmo_gnt_t", 32'(gnt_o[1]), 32'(3'b010));

    // Random traffic against the model, with sticky requests and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      nrst_in = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) req_in = N'($urandom_range(0, 7));
      a_in    = {16'($urandom), 16'($urandom), 16'($urandom)};
      r_nw_in = N'($urandom_range(0, 7));
      d_in    = {8'($urandom), 8'($urandom), 8'($urandom)};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
